udp_frame_gen: RTL and testbench
================================

Name: udp_frame_gen

Overview:
- Transmit-side counterpart of the packet header parser: turns one descriptor into one complete Ethernet/IPv4/UDP frame on an AXI-stream master.
- Payload is a deterministic byte pattern.
- Used to drive the ingress pipeline and parser with known traffic. The flow id is written into the UDP source port, so the parser's match-table lookup resolves back to the same flow.
- Byte n of the frame is carried in beat n/KEEP_WIDTH, lane tdata[(n%KEEP_WIDTH)*8 +: 8]. Multi-byte header fields are big-endian.

Parameters:
- DATA_WIDTH, 256, AXI-stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, bytes per beat.
- LEN_WIDTH, 16, descriptor length width.
- FLOW_WIDTH, 8, descriptor flow id width.
- DST_MAC, 48'h020000000002, Ethernet destination MAC.
- SRC_MAC, 48'h020000000001, Ethernet source MAC.
- SRC_IP, 32'h0A000001, IPv4 source address.
- DST_IP, 32'h0A000002, IPv4 destination address.
- DST_PORT, 16'h1234, UDP destination port.
- MIN_LEN, 60, minimum frame bytes.
- MAX_LEN, 1514, maximum frame bytes.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_desc_pk_len  in  LEN_WIDTH  total frame length in bytes, including the 14-byte Ethernet header
- s_desc_flow_id  in  FLOW_WIDTH  flow id, written to the UDP source port
- s_desc_valid  in  1  descriptor valid
- s_desc_ready  out  1  descriptor accepted when valid && ready
- m_axis_tdata  out  DATA_WIDTH  frame data
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tvalid  out  1  beat valid
- m_axis_tlast  out  1  last beat of frame
- m_axis_tready  in  1  downstream ready
- m_pkt_count  out  32  number of frames completed

Behaviour:
- Reset values: s_desc_ready=0 while rst is high, 1 from the first cycle after; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, m_pkt_count=0, id counter=0.
- States and transitions:
  - IDLE: s_desc_ready=1. On valid&&ready, latch L and flow_id → CSUM.
  - CSUM: s_desc_ready=0. Register the IPv4 header checksum and beat count → SEND.
  - SEND: tvalid=1, beat index starts at 0. Each tvalid&&tready advances the index. On the handshake of the last beat → IDLE.
- Length clamping: L = MIN_LEN if pk_len<MIN_LEN; L = MAX_LEN if pk_len>MAX_LEN; otherwise L = pk_len.
- Beat count = ceil(L/KEEP_WIDTH).
- Frame layout (byte offsets):
  - 0-5 DST_MAC; 6-11 SRC_MAC; 12-13 0x0800.
  - 14 0x45; 15 0x00; 16-17 IP total length = L-14; 18-19 id counter.
  - 20-21 0x4000; 22 0x40; 23 0x11; 24-25 checksum.
  - 26-29 SRC_IP; 30-33 DST_IP.
  - 34-35 flow_id, zero-extended; 36-37 DST_PORT; 38-39 UDP length = L-34; 40-41 0x0000.
  - 42..L-1: byte value = offset[7:0].
- Checksum:
  - 16-bit one's-complement sum of words 0x4500, L-14, id, 0x4000, 0x4011, 0x0000, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0].
  - Sum in a 20-bit accumulator, fold carries twice, then invert.
- tkeep: all ones on non-last beats. On the last beat, the low (L%KEEP_WIDTH) bits are set, or all ones if the remainder is 0. Bytes beyond L are driven 0.
- Latency: descriptor accepted in cycle T → first beat tvalid in T+2. Frame back-to-back spacing is ≥2 idle cycles (CSUM state + return to IDLE).
- AXI hold rule: while tvalid && !tready, tdata/tkeep/tlast are held stable. tvalid never drops mid-frame.
- On the tlast handshake:
  - m_pkt_count increments, wrapping at 2^32.
  - The id counter increments, wrapping 0xFFFF→0. The id is sampled into the frame at descriptor accept.
- Descriptors presented while not in IDLE are not accepted; s_desc_ready is low.
- Reset mid-frame: the frame is aborted. tvalid=0 the next cycle, no tlast is emitted, and the counters clear.

Test Plan:
- pk_len=60, flow_id=3, tready=1 → 2 beats, first tvalid 2 cycles after accept.
  - Bytes 12-13=08 00; 16-17=00 2E; 18-19=00 00; 24-25=26 BD; 34-35=00 03; 38-39=00 1A.
  - Beat 1 tkeep=0x0FFFFFFF, tlast=1; m_pkt_count=1.
- pk_len=100 → 4 beats; last tkeep=0x0000000F; byte 99=0x63; byte 42=0x2A.
- pk_len=20 → clamped to 60: identical length, tkeep and tlast to the first scenario. pk_len=2000 → 1514: 48 beats, last tkeep=0x3FF, bytes 16-17=05 DC.
- tready toggled 1-0-0-1 during a 4-beat frame → data/keep/last stable across stalls, no beats lost, exactly one tlast. Second frame has id bytes 18-19=00 01.
- Descriptor held valid during SEND → not accepted until IDLE; exactly one frame per handshake.
- rst asserted at beat 2 of 4 → next cycle tvalid=0, s_desc_ready=0; after release s_desc_ready=1, m_pkt_count=0, next frame id=0.

Source files
------------

// File: rtl/udp_frame_gen_if.sv
// AXI-stream bus carrying the generated Ethernet/IPv4/UDP frames.
interface udp_frame_gen_if #(
  parameter int DATA_WIDTH = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_frame_gen.sv
// Turns one descriptor (length, flow id) into one Ethernet/IPv4/UDP frame
// with a deterministic payload on an AXI-stream master.
module udp_frame_gen #(
  parameter int          DATA_WIDTH = 256,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int          LEN_WIDTH  = 16,
  parameter int          FLOW_WIDTH = 8,
  parameter logic [47:0] DST_MAC    = 48'h020000000002,
  parameter logic [47:0] SRC_MAC    = 48'h020000000001,
  parameter logic [31:0] SRC_IP     = 32'h0A000001,
  parameter logic [31:0] DST_IP     = 32'h0A000002,
  parameter logic [15:0] DST_PORT   = 16'h1234,
  parameter int          MIN_LEN    = 60,
  parameter int          MAX_LEN    = 1514
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  s_desc_pk_len,
  input  logic [FLOW_WIDTH-1:0] s_desc_flow_id,
  input  logic                  s_desc_valid,
  output logic                  s_desc_ready,
  udp_frame_gen_if.master       m_axis,
  output logic [31:0]           m_pkt_count
);
  localparam int KEEP_BITS = $clog2(KEEP_WIDTH);
  localparam int HDR_BYTES = 42;

  typedef enum logic [1:0] {IDLE, CSUM, SEND} state_t;

  state_t                state_reg;
  logic                  ready_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  beats_reg;
  logic [LEN_WIDTH-1:0]  beat_idx_reg;
  logic [FLOW_WIDTH-1:0] flow_reg;
  logic [15:0]           id_reg;
  logic [15:0]           id_cnt_reg;
  logic [15:0]           csum_reg;
  logic [31:0]           pkt_count_reg;
  logic [DATA_WIDTH-1:0] tdata_reg;
  logic [KEEP_WIDTH-1:0] tkeep_reg;
  logic                  tvalid_reg;
  logic                  tlast_reg;

  logic [LEN_WIDTH-1:0] len_clamped;
  always_comb begin
    len_clamped = s_desc_pk_len;
    if (s_desc_pk_len < LEN_WIDTH'(MIN_LEN)) begin
      len_clamped = LEN_WIDTH'(MIN_LEN);
    end else if (s_desc_pk_len > LEN_WIDTH'(MAX_LEN)) begin
      len_clamped = LEN_WIDTH'(MAX_LEN);
    end
  end

  logic [15:0] ip_len;
  logic [15:0] udp_len;
  logic [15:0] flow16;
  assign ip_len  = 16'(len_reg - LEN_WIDTH'(14));
  assign udp_len = 16'(len_reg - LEN_WIDTH'(34));
  assign flow16  = 16'(flow_reg);

  // Ten 16-bit words fit a 20-bit sum; two folds absorb every carry.
  logic [19:0] csum_sum;
  logic [16:0] csum_fold1;
  logic [15:0] csum_fold2;
  logic [15:0] csum_comb;
  assign csum_sum = 20'h04500 + 20'(ip_len) + 20'(id_reg) + 20'h04000 + 20'h04011
                  + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                  + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
  assign csum_fold1 = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
  assign csum_fold2 = csum_fold1[15:0] + 16'(csum_fold1[16]);
  assign csum_comb  = ~csum_fold2;

  logic [LEN_WIDTH-1:0] beats_comb;
  assign beats_comb = LEN_WIDTH'((32'(len_reg) + KEEP_WIDTH - 1) >> KEEP_BITS);

  // Beat 0 is built while still in CSUM, so it takes the checksum and
  // beat count straight from the combinational path.
  logic                 in_csum;
  logic [15:0]          csum_sel;
  logic [LEN_WIDTH-1:0] beats_sel;
  logic [LEN_WIDTH-1:0] build_idx;
  logic                 build_last;
  assign in_csum    = (state_reg == CSUM);
  assign csum_sel   = in_csum ? csum_comb : csum_reg;
  assign beats_sel  = in_csum ? beats_comb : beats_reg;
  assign build_idx  = in_csum ? '0 : beat_idx_reg + LEN_WIDTH'(1);
  assign build_last = (build_idx == beats_sel - LEN_WIDTH'(1));

  logic [7:0] hdr [0:63];
  always_comb begin
    for (int i = 0; i < 64; i++) begin
      hdr[i] = 8'h00;
    end
    for (int i = 0; i < 6; i++) begin
      hdr[i]     = DST_MAC[8*(5-i) +: 8];
      hdr[6 + i] = SRC_MAC[8*(5-i) +: 8];
    end
    hdr[12] = 8'h08;
    hdr[13] = 8'h00;
    hdr[14] = 8'h45;
    hdr[15] = 8'h00;
    hdr[16] = ip_len[15:8];
    hdr[17] = ip_len[7:0];
    hdr[18] = id_reg[15:8];
    hdr[19] = id_reg[7:0];
    hdr[20] = 8'h40;
    hdr[21] = 8'h00;
    hdr[22] = 8'h40;
    hdr[23] = 8'h11;
    hdr[24] = csum_sel[15:8];
    hdr[25] = csum_sel[7:0];
    for (int i = 0; i < 4; i++) begin
      hdr[26 + i] = SRC_IP[8*(3-i) +: 8];
      hdr[30 + i] = DST_IP[8*(3-i) +: 8];
    end
    hdr[34] = flow16[15:8];
    hdr[35] = flow16[7:0];
    hdr[36] = DST_PORT[15:8];
    hdr[37] = DST_PORT[7:0];
    hdr[38] = udp_len[15:8];
    hdr[39] = udp_len[7:0];
  end

  logic [DATA_WIDTH-1:0] build_data;
  logic [KEEP_WIDTH-1:0] build_keep;

  genvar gi;
  generate
    for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
      logic [LEN_WIDTH-1:0] off;
      logic                 keep;
      logic [7:0]           pattern;
      assign off     = (build_idx << KEEP_BITS) | LEN_WIDTH'(gi);
      assign keep    = (off < len_reg);
      assign pattern = (off < LEN_WIDTH'(HDR_BYTES)) ? hdr[off[5:0]] : off[7:0];
      assign build_keep[gi]       = keep;
      assign build_data[gi*8 +: 8] = keep ? pattern : 8'h00;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      len_reg       <= '0;
      beats_reg     <= '0;
      beat_idx_reg  <= '0;
      flow_reg      <= '0;
      id_reg        <= 16'h0000;
      id_cnt_reg    <= 16'h0000;
      csum_reg      <= 16'h0000;
      pkt_count_reg <= 32'd0;
      tdata_reg     <= '0;
      tkeep_reg     <= '0;
      tvalid_reg    <= 1'b0;
      tlast_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (s_desc_valid && ready_reg) begin
            len_reg   <= len_clamped;
            flow_reg  <= s_desc_flow_id;
            id_reg    <= id_cnt_reg;
            ready_reg <= 1'b0;
            state_reg <= CSUM;
          end
        end
        CSUM: begin
          csum_reg     <= csum_comb;
          beats_reg    <= beats_comb;
          beat_idx_reg <= '0;
          tdata_reg    <= build_data;
          tkeep_reg    <= build_keep;
          tlast_reg    <= build_last;
          tvalid_reg   <= 1'b1;
          state_reg    <= SEND;
        end
        SEND: begin
          if (m_axis.tready) begin
            if (tlast_reg) begin
              tvalid_reg    <= 1'b0;
              tlast_reg     <= 1'b0;
              tkeep_reg     <= '0;
              tdata_reg     <= '0;
              pkt_count_reg <= pkt_count_reg + 32'd1;
              id_cnt_reg    <= id_cnt_reg + 16'd1;
              ready_reg     <= 1'b1;
              state_reg     <= IDLE;
            end else begin
              beat_idx_reg <= build_idx;
              tdata_reg    <= build_data;
              tkeep_reg    <= build_keep;
              tlast_reg    <= build_last;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign s_desc_ready  = ready_reg;
  assign m_pkt_count   = pkt_count_reg;
  assign m_axis.tdata  = tdata_reg;
  assign m_axis.tkeep  = tkeep_reg;
  assign m_axis.tvalid = tvalid_reg;
  assign m_axis.tlast  = tlast_reg;
endmodule

// File: tb/tb_udp_frame_gen.sv
// Self-checking bench for udp_frame_gen: frames are compared byte by byte
// against a byte-array model of the frame built from the layout rules.
module tb_udp_frame_gen;
  localparam int KW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] desc_len;
  logic [7:0]  desc_flow;
  logic        desc_valid;
  logic        desc_ready;
  logic [31:0] pkt_count;

  always #5 clk = ~clk;

  udp_frame_gen_if #(.DATA_WIDTH(256)) axis_if ();

  udp_frame_gen dut (
    .clk           (clk),
    .rst           (rst),
    .s_desc_pk_len (desc_len),
    .s_desc_flow_id(desc_flow),
    .s_desc_valid  (desc_valid),
    .s_desc_ready  (desc_ready),
    .m_axis        (axis_if),
    .m_pkt_count   (pkt_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_id;
  int exp_pkt;

  logic [7:0] exp_bytes [0:2047];
  int         exp_len;
  int         exp_beats;

  logic [255:0] cap_data [0:63];
  logic [31:0]  cap_keep [0:63];
  logic         cap_last [0:63];
  int cap_n, cap_lat, cap_unstable, cap_drop, cap_extra_acc;
  int cap_tlast_cnt, cap_timeout, cap_ready_send;

  // Reference frame built directly from the byte layout.
  task automatic model_frame(input int pk_len, input int flow, input int id);
    logic [47:0] dmac;
    logic [47:0] smac;
    int words [10];
    int sum;
    int csum;
    dmac = 48'h020000000002;
    smac = 48'h020000000001;
    exp_len   = (pk_len < 60) ? 60 : ((pk_len > 1514) ? 1514 : pk_len);
    exp_beats = (exp_len + KW - 1) / KW;
    for (int n = 0; n < 2048; n++) exp_bytes[n] = 8'(n);
    for (int i = 0; i < 6; i++) begin
      exp_bytes[i]     = dmac[47 - 8*i -: 8];
      exp_bytes[6 + i] = smac[47 - 8*i -: 8];
    end
    words = '{32'h4500, exp_len - 14, id, 32'h4000, 32'h4011, 0,
              32'h0A00, 32'h0001, 32'h0A00, 32'h0002};
    sum = 0;
    foreach (words[i]) sum += words[i];
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    csum = (~sum) & 32'hFFFF;
    exp_bytes[12] = 8'h08;  exp_bytes[13] = 8'h00;
    exp_bytes[14] = 8'h45;  exp_bytes[15] = 8'h00;
    exp_bytes[16] = 8'((exp_len - 14) >> 8);  exp_bytes[17] = 8'(exp_len - 14);
    exp_bytes[18] = 8'(id >> 8);  exp_bytes[19] = 8'(id);
    exp_bytes[20] = 8'h40;  exp_bytes[21] = 8'h00;
    exp_bytes[22] = 8'h40;  exp_bytes[23] = 8'h11;
    exp_bytes[24] = 8'(csum >> 8);  exp_bytes[25] = 8'(csum);
    exp_bytes[26] = 8'h0A;  exp_bytes[27] = 8'h00;  exp_bytes[28] = 8'h00;  exp_bytes[29] = 8'h01;
    exp_bytes[30] = 8'h0A;  exp_bytes[31] = 8'h00;  exp_bytes[32] = 8'h00;  exp_bytes[33] = 8'h02;
    exp_bytes[34] = 8'h00;  exp_bytes[35] = 8'(flow);
    exp_bytes[36] = 8'h12;  exp_bytes[37] = 8'h34;
    exp_bytes[38] = 8'((exp_len - 34) >> 8);  exp_bytes[39] = 8'(exp_len - 34);
    exp_bytes[40] = 8'h00;  exp_bytes[41] = 8'h00;
  endtask

  function automatic int beat_diffs();
    int d;
    int nb;
    logic [255:0] ed;
    logic [31:0]  ek;
    logic         el;
    d  = 0;
    nb = (cap_n < exp_beats) ? cap_n : exp_beats;
    if (nb > 64) nb = 64;
    for (int b = 0; b < nb; b++) begin
      ed = '0;
      ek = '0;
      for (int j = 0; j < KW; j++) begin
        if (b*KW + j < exp_len) begin
          ed[j*8 +: 8] = exp_bytes[b*KW + j];
          ek[j] = 1'b1;
        end
      end
      el = (b == exp_beats - 1);
      if (cap_data[b] !== ed || cap_keep[b] !== ek || cap_last[b] !== el) begin
        d++;
        if (d == 1)
          $display("  beat %0d: data %h keep %h last %0d, model data %h keep %h last %0d",
                   b, cap_data[b], cap_keep[b], cap_last[b], ed, ek, el);
      end
    end
    return d;
  endfunction

  function automatic logic [7:0] got_byte(input int n);
    logic [255:0] w;
    w = cap_data[(n / KW) % 64];
    return w[(n % KW)*8 +: 8];
  endfunction

  // Drives one descriptor and captures the frame; rmode 0 = always ready,
  // 1 = random ready, 2 = repeating 1-0-0-1 ready pattern.
  task automatic run_frame(input int pk_len, input int flow, input int rmode, input bit hold);
    int guard;
    int step;
    bit held;
    bit done;
    logic [255:0] hd;
    logic [31:0]  hk;
    logic         hl;
    logic         r;
    cap_n = 0; cap_lat = 0; cap_unstable = 0; cap_drop = 0; cap_extra_acc = 0;
    cap_tlast_cnt = 0; cap_timeout = 0; cap_ready_send = 0;
    hd = '0; hk = '0; hl = 1'b0;
    model_frame(pk_len, flow, exp_id);
    desc_len   = 16'(pk_len);
    desc_flow  = 8'(flow);
    desc_valid = 1'b1;
    guard = 0;
    while (desc_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (desc_ready !== 1'b1) begin
      cap_timeout = 1;
      desc_valid  = 1'b0;
      return;
    end
    @(negedge clk);
    if (!hold) desc_valid = 1'b0;
    cap_lat = 1;
    while (axis_if.tvalid !== 1'b1 && cap_lat < 50) begin
      @(negedge clk);
      cap_lat++;
    end
    if (axis_if.tvalid !== 1'b1) begin
      cap_timeout = 1;
      return;
    end
    step = 0; held = 1'b0; done = 1'b0; guard = 0;
    while (!done && guard < 3000) begin
      if (axis_if.tvalid !== 1'b1) cap_drop++;
      if (desc_ready === 1'b1) cap_ready_send++;
      if (desc_valid && desc_ready === 1'b1) cap_extra_acc++;
      if (held && (axis_if.tdata !== hd || axis_if.tkeep !== hk || axis_if.tlast !== hl))
        cap_unstable++;
      case (rmode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = !((step % 4 == 1) || (step % 4 == 2));
      endcase
      axis_if.tready = r;
      step++;
      if (axis_if.tvalid === 1'b1 && r) begin
        if (cap_n < 64) begin
          cap_data[cap_n] = axis_if.tdata;
          cap_keep[cap_n] = axis_if.tkeep;
          cap_last[cap_n] = axis_if.tlast;
        end
        cap_n++;
        if (axis_if.tlast === 1'b1) begin
          cap_tlast_cnt++;
          done = 1'b1;
        end
        held = 1'b0;
      end else begin
        held = (axis_if.tvalid === 1'b1);
        hd = axis_if.tdata;
        hk = axis_if.tkeep;
        hl = axis_if.tlast;
      end
      @(negedge clk);
      guard++;
    end
    axis_if.tready = 1'b0;
    if (!done) begin
      cap_timeout = 1;
    end else begin
      exp_id  = (exp_id + 1) & 32'hFFFF;
      exp_pkt = exp_pkt + 1;
    end
    $display("frame len=%0d flow=%0d id=%0d beats=%0d latency=%0d", pk_len, flow,
             (exp_id - 1) & 32'hFFFF, cap_n, cap_lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    desc_valid = 1'b0;
    axis_if.tready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (desc_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", desc_ready); end
    checks++; if (axis_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", axis_if.tvalid); end
    checks++; if (axis_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b, required 0", axis_if.tlast); end
    checks++; if (axis_if.tkeep !== 32'h0) begin errors++; $display("FAIL reset_tkeep: got %h, required 0", axis_if.tkeep); end
    checks++; if (axis_if.tdata !== 256'h0) begin errors++; $display("FAIL reset_tdata: got %h, required 0", axis_if.tdata); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d, required 0", pkt_count); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, required 1", desc_ready); end
    exp_id  = 0;
    exp_pkt = 0;
    $display("reset done");
  endtask

  task automatic test_basic();
    run_frame(60, 3, 0, 0);
    checks++; if (cap_timeout !== 0) begin errors++; $display("FAIL basic_timeout: got %0d, required 0", cap_timeout); end
    checks++; if (cap_lat !== 2) begin errors++; $display("FAIL basic_latency: got %0d cycles, required 2", cap_lat); end
    checks++; if (cap_n !== 2) begin errors++; $display("FAIL basic_beats: got %0d, required 2", cap_n); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL basic_model: got %0d differing beats, required 0", beat_diffs()); end
    checks++; if ({got_byte(12), got_byte(13)} !== 16'h0800) begin errors++; $display("FAIL basic_ethertype: got %h, required 0800", {got_byte(12), got_byte(13)}); end
    checks++; if ({got_byte(16), got_byte(17)} !== 16'h002E) begin errors++; $display("FAIL basic_ip_len: got %h, required 002e", {got_byte(16), got_byte(17)}); end
    checks++; if ({got_byte(18), got_byte(19)} !== 16'h0000) begin errors++; $display("FAIL basic_id: got %h, required 0000", {got_byte(18), got_byte(19)}); end
    checks++; if ({got_byte(24), got_byte(25)} !== 16'h26BD) begin errors++; $display("FAIL basic_csum: got %h, required 26bd", {got_byte(24), got_byte(25)}); end
    checks++; if ({got_byte(34), got_byte(35)} !== 16'h0003) begin errors++; $display("FAIL basic_sport: got %h, required 0003", {got_byte(34), got_byte(35)}); end
    checks++; if ({got_byte(38), got_byte(39)} !== 16'h001A) begin errors++; $display("FAIL basic_udp_len: got %h, required 001a", {got_byte(38), got_byte(39)}); end
    checks++; if (cap_keep[1] !== 32'h0FFFFFFF || cap_last[1] !== 1'b1) begin errors++; $display("FAIL basic_last_beat: got keep %h last %b, required 0fffffff 1", cap_keep[1], cap_last[1]); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL basic_pkt_count: got %0d, required 1", pkt_count); end
  endtask

  task automatic test_clamp_lengths();
    run_frame(100, 7, 0, 0);
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL len100_beats: got %0d, required 4", cap_n); end
    checks++; if (cap_keep[3] !== 32'h0000000F) begin errors++; $display("FAIL len100_keep: got %h, required 0000000f", cap_keep[3]); end
    checks++; if (got_byte(99) !== 8'h63 || got_byte(42) !== 8'h2A) begin errors++; $display("FAIL len100_payload: got %h %h, required 63 2a", got_byte(99), got_byte(42)); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL len100_model: got %0d differing beats, required 0", beat_diffs()); end

    run_frame(20, 4, 0, 0);
    checks++; if (cap_n !== 2) begin errors++; $display("FAIL len20_beats: got %0d, required 2", cap_n); end
    checks++; if (cap_keep[1] !== 32'h0FFFFFFF || cap_last[1] !== 1'b1) begin errors++; $display("FAIL len20_last: got keep %h last %b, required 0fffffff 1", cap_keep[1], cap_last[1]); end
    checks++; if ({got_byte(16), got_byte(17)} !== 16'h002E) begin errors++; $display("FAIL len20_ip_len: got %h, required 002e", {got_byte(16), got_byte(17)}); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL len20_model: got %0d differing beats, required 0", beat_diffs()); end

    run_frame(2000, 200, 0, 0);
    checks++; if (cap_n !== 48) begin errors++; $display("FAIL len2000_beats: got %0d, required 48", cap_n); end
    checks++; if (cap_keep[47] !== 32'h000003FF) begin errors++; $display("FAIL len2000_keep: got %h, required 000003ff", cap_keep[47]); end
    checks++; if ({got_byte(16), got_byte(17)} !== 16'h05DC) begin errors++; $display("FAIL len2000_ip_len: got %h, required 05dc", {got_byte(16), got_byte(17)}); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL len2000_model: got %0d differing beats, required 0", beat_diffs()); end
    checks++; if (pkt_count !== 32'(exp_pkt)) begin errors++; $display("FAIL len_pkt_count: got %0d, required %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_desc_hold();
    int late_valid;
    run_frame(200, 33, 1, 1);
    checks++; if (cap_extra_acc !== 0 || cap_ready_send !== 0) begin errors++; $display("FAIL hold_accept_during_send: got %0d ready cycles, required 0", cap_ready_send); end
    checks++; if (cap_tlast_cnt !== 1 || beat_diffs() !== 0) begin errors++; $display("FAIL hold_frame1: got tlast %0d diffs %0d, required 1 0", cap_tlast_cnt, beat_diffs()); end
    run_frame(200, 33, 0, 0);
    checks++; if (cap_lat !== 2) begin errors++; $display("FAIL hold_b2b_latency: got %0d, required 2", cap_lat); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL hold_frame2: got %0d differing beats, required 0", beat_diffs()); end
    late_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (axis_if.tvalid === 1'b1) late_valid++;
    end
    checks++; if (late_valid !== 0) begin errors++; $display("FAIL hold_extra_frame: got %0d valid cycles, required 0", late_valid); end
    checks++; if (pkt_count !== 32'(exp_pkt)) begin errors++; $display("FAIL hold_pkt_count: got %0d, required %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_random();
    int bl [9];
    int len;
    int flow;
    bl = '{0, 59, 60, 61, 64, 1513, 1514, 1515, 65535};
    for (int k = 0; k < 16; k++) begin
      len  = ($urandom_range(0, 4) == 0) ? bl[$urandom_range(0, 8)] : int'($urandom_range(0, 1600));
      flow = int'($urandom_range(0, 255));
      run_frame(len, flow, 1, 0);
      checks++; if (cap_timeout !== 0 || cap_lat !== 2) begin errors++; $display("FAIL rand_handshake: got timeout %0d latency %0d, required 0 2", cap_timeout, cap_lat); end
      checks++; if (cap_n !== exp_beats) begin errors++; $display("FAIL rand_beats: got %0d, required %0d", cap_n, exp_beats); end
      checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL rand_model: got %0d differing beats, required 0", beat_diffs()); end
      checks++; if (cap_unstable !== 0 || cap_drop !== 0) begin errors++; $display("FAIL rand_axi_hold: got unstable %0d drops %0d, required 0 0", cap_unstable, cap_drop); end
      checks++; if (pkt_count !== 32'(exp_pkt)) begin errors++; $display("FAIL rand_pkt_count: got %0d, required %0d", pkt_count, exp_pkt); end
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    int xfers;
    bit seen_last;
    desc_len = 16'd100; desc_flow = 8'd9; desc_valid = 1'b1;
    guard = 0;
    while (desc_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    desc_valid = 1'b0;
    axis_if.tready = 1'b1;
    xfers = 0; seen_last = 1'b0; guard = 0;
    while (xfers < 2 && guard < 50) begin
      if (axis_if.tvalid === 1'b1) begin
        xfers++;
        if (axis_if.tlast === 1'b1) seen_last = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    checks++; if (xfers !== 2 || seen_last !== 1'b0) begin errors++; $display("FAIL midrst_prefix: got %0d beats tlast %b, required 2 0", xfers, seen_last); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (axis_if.tvalid !== 1'b0 || axis_if.tlast !== 1'b0) begin errors++; $display("FAIL midrst_abort: got tvalid %b tlast %b, required 0 0", axis_if.tvalid, axis_if.tlast); end
    checks++; if (desc_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b, required 0", desc_ready); end
    checks++; if (pkt_count !== 32'd0) begin errors++; $display("FAIL midrst_pkt_count: got %0d, required 0", pkt_count); end
    rst = 1'b0;
    axis_if.tready = 1'b0;
    @(negedge clk);
    checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b, required 1", desc_ready); end
    exp_id  = 0;
    exp_pkt = 0;
    $display("reset applied mid-frame after %0d beats", xfers);
    run_frame(100, 9, 0, 0);
    checks++; if ({got_byte(18), got_byte(19)} !== 16'h0000) begin errors++; $display("FAIL midrst_id: got %h, required 0000", {got_byte(18), got_byte(19)}); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL midrst_model: got %0d differing beats, required 0", beat_diffs()); end
    checks++; if (pkt_count !== 32'd1) begin errors++; $display("FAIL midrst_count_after: got %0d, required 1", pkt_count); end
  endtask

  task automatic test_stall();
    int late_valid;
    run_frame(100, 85, 2, 0);
    checks++; if (cap_n !== 4 || cap_tlast_cnt !== 1) begin errors++; $display("FAIL stall_beats: got %0d beats %0d tlast, required 4 1", cap_n, cap_tlast_cnt); end
    checks++; if (cap_unstable !== 0 || cap_drop !== 0) begin errors++; $display("FAIL stall_hold: got unstable %0d drops %0d, required 0 0", cap_unstable, cap_drop); end
    checks++; if (beat_diffs() !== 0) begin errors++; $display("FAIL stall_model: got %0d differing beats, required 0", beat_diffs()); end
    checks++; if ({got_byte(18), got_byte(19)} !== 16'h0001) begin errors++; $display("FAIL stall_id: got %h, required 0001", {got_byte(18), got_byte(19)}); end
    late_valid = 0;
    repeat (4) begin
      @(negedge clk);
      if (axis_if.tvalid === 1'b1 || axis_if.tlast === 1'b1) late_valid++;
    end
    checks++; if (late_valid !== 0) begin errors++; $display("FAIL stall_trailing_beats: got %0d, required 0", late_valid); end
    checks++; if (pkt_count !== 32'd2) begin errors++; $display("FAIL stall_pkt_count: got %0d, required 2", pkt_count); end
  endtask

  initial begin
    rst            = 1'b1;
    desc_len       = 16'd0;
    desc_flow      = 8'd0;
    desc_valid     = 1'b0;
    axis_if.tready = 1'b0;
    exp_id         = 0;
    exp_pkt        = 0;
    test_reset();
    test_basic();
    test_clamp_lengths();
    test_desc_hold();
    test_random();
    test_mid_reset();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
